// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared arbiter types, default sizes and round-robin search helper
package arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int ARB_NUM_REQ = 15;
  localparam int ARB_IDX_W   = 4;

  // Widest request vector the search helper handles; callers zero-extend into it.
  localparam int ARB_MAX_REQ = 32;

  // First set bit of req[num_req-1:0], searching upward from last+1 and
  // wrapping modulo num_req. Returns -1 when no bit is set.
  function automatic int rr_first_set(input logic [ARB_MAX_REQ-1:0] req,
                                      input int                     num_req,
                                      input int                     last);
    int                     idx;
    bit                     found;
    logic [ARB_MAX_REQ-1:0] shifted;
    rr_first_set = -1;
    found        = 1'b0;
    for (int k = 1; k <= ARB_MAX_REQ; k++) begin
      if (k <= num_req) begin
        idx = last + k;
        if (idx >= num_req) begin
          idx = idx - num_req;
        end
        shifted = req >> idx;
        if (!found && shifted[0]) begin
          rr_first_set = idx;
          found        = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/gnt_dec.sv
// rtl/gnt_dec.sv - binary index to one-hot decoder gated by a valid bit
module gnt_dec #(
  parameter int NUM_REQ = 15,
  parameter int IDX_W   = 4
) (
  input  logic               valid,
  input  logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] onehot
);

  // Bit i is set only for a valid grant on index i; out-of-range indices decode to zero.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (valid && (idx == IDX_W'(i))) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_rr_onehot.sv
// rtl/arb_rr_onehot.sv - locking round-robin arbiter with binary and one-hot grant; ARB_TIMEOUT_EN adds forced release
import arb_pkg::*;

module arb_rr_onehot #(
  parameter int NUM_REQ        = ARB_NUM_REQ,
  parameter int IDX_W          = ARB_IDX_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic               timeout
);

  // Reject configurations the search helper and counter cannot honour.
  if ((NUM_REQ < 2) || (NUM_REQ > (2 ** IDX_W)) || (NUM_REQ > ARB_MAX_REQ) ||
      (TIMEOUT_CYCLES < 2)) begin : g_bad_cfg
    $error("arb_rr_onehot: illegal NUM_REQ/IDX_W/TIMEOUT_CYCLES");
  end

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [IDX_W-1:0]        ptr;
  logic [ARB_MAX_REQ-1:0]  req_ext;
  logic                    rel;
  logic                    expire;
  int                      win;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif

  // Widen the request vector; bits at or above NUM_REQ stay zero.
  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
  end

  // State register: grant holder, priority pointer and hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_idx_q <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      last_q    <= last_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // Next state: lock the grant in BUSY, re-arbitrate from the released index on release.
  always_comb begin
    expire    = 1'b0;
`ifdef ARB_TIMEOUT_EN
    expire    = (state_q == BUSY) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    cnt_d     = cnt_q;
`endif
    rel       = (state_q == BUSY) && (done || expire);
    // The pointer update on release must be visible to this cycle's search.
    ptr       = rel ? gnt_idx_q : last_q;
    win       = rr_first_set(req_ext, NUM_REQ, int'(ptr));
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    last_d    = last_q;
    case (state_q)
      IDLE: begin
        if (win >= 0) begin
          state_d   = BUSY;
          gnt_idx_d = IDX_W'(win);
`ifdef ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      BUSY: begin
        if (rel) begin
          last_d = gnt_idx_q;
          if (win >= 0) begin
            gnt_idx_d = IDX_W'(win);
`ifdef ARB_TIMEOUT_EN
            cnt_d     = '0;
`endif
          end else begin
            state_d = IDLE;
          end
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: valid follows the registered state; timeout only when expiry forces the release.
  always_comb begin
    gnt_valid = (state_q == BUSY);
    gnt_idx   = gnt_idx_q;
`ifdef ARB_TIMEOUT_EN
    timeout   = expire && !done;
`else
    timeout   = 1'b0;
`endif
  end

  gnt_dec #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_gnt_dec (
    .valid  (gnt_valid),
    .idx    (gnt_idx_q),
    .onehot (gnt_onehot)
  );

endmodule

// File: tb/tb_arb_rr_onehot.sv
// tb/tb_arb_rr_onehot.sv - directed self-checking bench for arb_rr_onehot
module tb_arb_rr_onehot;

  logic        clk;
  logic        rst;
  logic [14:0] req;
  logic        done;
  logic        gnt_valid;
  logic [3:0]  gnt_idx;
  logic [14:0] gnt_onehot;
  logic        timeout;

  int n_cmp;
  int n_bad;

  arb_rr_onehot #(
    .NUM_REQ        (15),
    .IDX_W          (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .done       (done),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input int idx);
    chk({tag, ".valid"}, 32'(gnt_valid), 32'd1);
    chk({tag, ".idx"}, 32'(gnt_idx), 32'(idx));
    chk({tag, ".onehot"}, 32'(gnt_onehot), 32'd1 << idx);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, 32'(gnt_valid), 32'd0);
    chk({tag, ".onehot"}, 32'(gnt_onehot), 32'd0);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    done = 1'b0;
    req  = '0;
    step();
    rst  = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    done  = 1'b0;
    req   = 15'h7FFF;

    // Reset held two cycles with every request up.
    for (int i = 0; i < 2; i++) begin
      step();
      chk_idle("reset");
      chk("reset.idx", 32'(gnt_idx), 32'd0);
      chk("reset.timeout", 32'(timeout), 32'd0);
    end

    // Single request: one-cycle latency, then release to idle.
    rst = 1'b0;
    req = 15'h0008;
    step();
    chk_grant("single", 3);
    done = 1'b1;
    req  = '0;
    step();
    chk_idle("single_rel");
    // done in IDLE is ignored.
    step();
    chk_idle("done_in_idle");
    done = 1'b0;

    // Fairness: all requesting, done every cycle, no bubbles.
    do_reset();
    req = 15'h7FFF;
    step();
    chk_grant("fair0", 0);
    done = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk_grant($sformatf("fair%0d", k), k % 15);
    end
    done = 1'b0;

    // Lock on 13 through request changes, then wrap to 0, then 5.
    do_reset();
    req = 15'h2000;
    step();
    chk_grant("lock_set", 13);
    req = 15'h0021;
    step();
    chk_grant("lock_hold1", 13);
    step();
    chk_grant("lock_hold2", 13);
    done = 1'b1;
    step();
    chk_grant("wrap", 0);
    step();
    chk_grant("after_wrap", 5);
    req = '0;
    step();
    chk_idle("lock_end");
    done = 1'b0;

    // Sole requester releasing is re-granted with no gap.
    req = 15'h0010;
    step();
    chk_grant("regrant_a", 4);
    done = 1'b1;
    step();
    chk_grant("regrant_b", 4);
    done = 1'b0;

    // Mid-grant reset (with done high: reset wins), pointer back to 14.
    do_reset();
    req = 15'h0080;
    step();
    chk_grant("mid_set", 7);
    rst  = 1'b1;
    done = 1'b1;
    step();
    chk_idle("mid_rst");
    chk("mid_rst.idx", 32'(gnt_idx), 32'd0);
    rst  = 1'b0;
    done = 1'b0;
    step();
    chk_grant("mid_after", 7);

    // Hold behaviour with no done: forced release or indefinite hold.
    do_reset();
    req = 15'h0006;
    step();
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 8; c++) begin
      chk_grant($sformatf("to_hold%0d", c), 1);
      chk($sformatf("to_pulse%0d", c), 32'(timeout), (c == 7) ? 32'd1 : 32'd0);
      step();
    end
    chk_grant("to_next", 2);
    chk("to_next.timeout", 32'(timeout), 32'd0);
`else
    for (int c = 0; c < 100; c++) begin
      chk($sformatf("hold_idx%0d", c), 32'(gnt_idx), 32'd1);
      chk($sformatf("hold_to%0d", c), 32'(timeout), 32'd0);
      step();
    end
    chk_grant("hold_end", 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
